// File: rtl/disp_pkg.sv
// Shared types and constants for the two-digit display scheduler:
// source FSM states, blank pattern and active-low digit table {a,b,c,d,e,f,g}.
package disp_pkg;

   typedef enum logic {LOC = 1'b0, IR = 1'b1} state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Index 9 first: packed concatenation fills from the MSB entry down.
   localparam logic [9:0][6:0] SEG_TBL = {
      7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
      7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
   };

   function automatic logic [6:0] clamp99(input logic [7:0] v);
      return (v > 8'd99) ? 7'd99 : v[6:0];
   endfunction

endpackage

// File: rtl/seg7_enc.sv
// Digit-to-segment lookup, active-low; codes above 9 render blank.
module seg7_enc
   import disp_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] pat
);

   always_comb begin
      pat = SEG_BLANK;
      if (digit <= 4'd9) pat = SEG_TBL[digit];
   end

endmodule

// File: rtl/disp_sched.sv
// Two-digit multiplexed display: local level source vs. held remote value.
// Build option LEAD_BLANK_EN blanks a zero tens digit.
module disp_sched
   import disp_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int HOLD_SCANS = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ir_valid,
   input  logic [7:0] ir_val,
   input  logic       ir_sign,
   input  logic [7:0] loc_val,
   input  logic       loc_sign,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       sign_led,
   output logic       src_ir,
   output logic       ovf
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int HW = $clog2(HOLD_SCANS + 1);
   localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_SCANS);

   state_t        state, state_nxt;
   logic [PW-1:0] ps_cnt;
   logic [HW-1:0] hold, hold_nxt;
   logic [6:0]    mag, mag_nxt;
   logic          neg_nxt, ovf_nxt, tick;
   logic [1:0]    an_nxt;
   logic [3:0]    tens, units, digit;
   logic [6:0]    pat, seg_nxt;

   assign tick = (ps_cnt == PS_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= LOC;
      else        state <= state_nxt;
   end

   // ir_valid outranks hold expiry so a fresh remote value is never dropped.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold;
      mag_nxt   = mag;
      neg_nxt   = sign_led;
      ovf_nxt   = ovf;
      case (state)
         LOC:     if (ir_valid) state_nxt = IR;
         IR:      if (!ir_valid && hold == HOLD_MAX) state_nxt = LOC;
         default: state_nxt = LOC;
      endcase
      if (ir_valid) begin
         hold_nxt = '0;
         mag_nxt  = clamp99(ir_val);
         neg_nxt  = ir_sign;
         ovf_nxt  = (ir_val > 8'd99);
      end else if (state_nxt == LOC) begin
         hold_nxt = '0;
         mag_nxt  = clamp99(loc_val);
         neg_nxt  = loc_sign;
         ovf_nxt  = (loc_val > 8'd99);
      end else if (tick && hold != HOLD_MAX) begin
         hold_nxt = hold + 1'b1;
      end
   end

   // Segments are decoded from next-cycle values so seg, an and value move together.
   assign an_nxt = tick ? ~an : an;
   assign tens   = 4'(mag_nxt / 7'd10);
   assign units  = 4'(mag_nxt % 7'd10);
   assign digit  = (an_nxt == 2'b10) ? units : tens;

   seg7_enc u_enc (.digit(digit), .pat(pat));

   always_comb begin
      seg_nxt = pat;
`ifdef LEAD_BLANK_EN
      if (an_nxt == 2'b01 && tens == 4'd0) seg_nxt = SEG_BLANK;
`else
      seg_nxt = pat;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ps_cnt   <= '0;
         hold     <= '0;
         mag      <= '0;
         sign_led <= 1'b0;
         ovf      <= 1'b0;
         src_ir   <= 1'b0;
         an       <= 2'b10;
         seg      <= SEG_TBL[0];
      end else begin
         ps_cnt   <= tick ? '0 : ps_cnt + 1'b1;
         hold     <= hold_nxt;
         mag      <= mag_nxt;
         sign_led <= neg_nxt;
         ovf      <= ovf_nxt;
         src_ir   <= (state_nxt == IR);
         an       <= an_nxt;
         seg      <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with SCAN_DIV=4, HOLD_SCANS=3; edge numbers in
// comments count rising edges since reset release.
module tb_disp_sched;

   logic       clk = 1'b0;
   logic       rst_n, ir_valid, ir_sign, loc_sign;
   logic [7:0] ir_val, loc_val;
   logic [6:0] seg;
   logic [1:0] an;
   logic       sign_led, src_ir, ovf;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef LEAD_BLANK_EN
   localparam logic [6:0] TENS0 = 7'b1111111;
`else
   localparam logic [6:0] TENS0 = 7'b0000001;
`endif

   disp_sched #(.SCAN_DIV(4), .HOLD_SCANS(3)) dut (
      .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid), .ir_val(ir_val),
      .ir_sign(ir_sign), .loc_val(loc_val), .loc_sign(loc_sign),
      .seg(seg), .an(an), .sign_led(sign_led), .src_ir(src_ir), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ir_valid = 1'b0; ir_val = '0; ir_sign = 1'b0;
      loc_val = '0; loc_sign = 1'b0;
      step(2);
      n_tests++; if (an !== 2'b10) begin n_fail++; $display("FAIL reset_an: got %b expected 10", an); end
      n_tests++; if (seg !== 7'b0000001) begin n_fail++; $display("FAIL reset_seg: got %b expected 0000001", seg); end
      n_tests++; if (sign_led !== 1'b0) begin n_fail++; $display("FAIL reset_sign: got %b expected 0", sign_led); end
      n_tests++; if (src_ir !== 1'b0) begin n_fail++; $display("FAIL reset_src: got %b expected 0", src_ir); end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
   endtask

   task automatic test_local();
      loc_val = 8'd42; loc_sign = 1'b1; rst_n = 1'b1;
      step(1); // e1
      n_tests++; if (an !== 2'b10) begin n_fail++; $display("FAIL loc_an_e1: got %b expected 10", an); end
      n_tests++; if (seg !== 7'b0010010) begin n_fail++; $display("FAIL loc_units: got %b expected 0010010", seg); end
      n_tests++; if (sign_led !== 1'b1) begin n_fail++; $display("FAIL loc_sign: got %b expected 1", sign_led); end
      n_tests++; if (src_ir !== 1'b0) begin n_fail++; $display("FAIL loc_src: got %b expected 0", src_ir); end
      step(2); // e3
      n_tests++; if (an !== 2'b10) begin n_fail++; $display("FAIL loc_an_e3: got %b expected 10", an); end
      step(1); // e4
      n_tests++; if (an !== 2'b01) begin n_fail++; $display("FAIL loc_an_e4: got %b expected 01", an); end
      n_tests++; if (seg !== 7'b1001100) begin n_fail++; $display("FAIL loc_tens: got %b expected 1001100", seg); end
      step(4); // e8
      n_tests++; if (an !== 2'b10) begin n_fail++; $display("FAIL loc_an_e8: got %b expected 10", an); end
   endtask

   task automatic test_ir();
      ir_valid = 1'b1; ir_val = 8'd7; ir_sign = 1'b0;
      step(1); // e9
      ir_valid = 1'b0;
      n_tests++; if (src_ir !== 1'b1) begin n_fail++; $display("FAIL ir_src_on: got %b expected 1", src_ir); end
      n_tests++; if (seg !== 7'b0001111) begin n_fail++; $display("FAIL ir_units: got %b expected 0001111", seg); end
      n_tests++; if (sign_led !== 1'b0) begin n_fail++; $display("FAIL ir_sign: got %b expected 0", sign_led); end
      step(11); // e20: third tick in IR
      n_tests++; if (src_ir !== 1'b1) begin n_fail++; $display("FAIL ir_src_e20: got %b expected 1", src_ir); end
      step(1); // e21: expiry
      n_tests++; if (src_ir !== 1'b0) begin n_fail++; $display("FAIL ir_src_off: got %b expected 0", src_ir); end
      n_tests++; if (an !== 2'b01) begin n_fail++; $display("FAIL ir_back_an: got %b expected 01", an); end
      n_tests++; if (seg !== 7'b1001100) begin n_fail++; $display("FAIL ir_back_seg: got %b expected 1001100", seg); end
      n_tests++; if (sign_led !== 1'b1) begin n_fail++; $display("FAIL ir_back_sign: got %b expected 1", sign_led); end
   endtask

   task automatic test_back_to_back();
      ir_valid = 1'b1; ir_val = 8'd7; ir_sign = 1'b0;
      step(1); // e22
      ir_valid = 1'b0;
      step(6); // e28: two ticks taken
      ir_valid = 1'b1; ir_val = 8'd15; ir_sign = 1'b1;
      step(1); // e29
      ir_valid = 1'b0;
      n_tests++; if (src_ir !== 1'b1) begin n_fail++; $display("FAIL b2b_src: got %b expected 1", src_ir); end
      n_tests++; if (sign_led !== 1'b1) begin n_fail++; $display("FAIL b2b_sign: got %b expected 1", sign_led); end
      n_tests++; if (seg !== 7'b1001111) begin n_fail++; $display("FAIL b2b_tens: got %b expected 1001111", seg); end
      step(3); // e32
      n_tests++; if (an !== 2'b10) begin n_fail++; $display("FAIL b2b_an: got %b expected 10", an); end
      n_tests++; if (seg !== 7'b0100100) begin n_fail++; $display("FAIL b2b_units: got %b expected 0100100", seg); end
      step(1); // e33: old hold would have expired here
      n_tests++; if (src_ir !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b expected 1", src_ir); end
      step(7); // e40
      n_tests++; if (src_ir !== 1'b1) begin n_fail++; $display("FAIL b2b_src_e40: got %b expected 1", src_ir); end
      step(1); // e41
      n_tests++; if (src_ir !== 1'b0) begin n_fail++; $display("FAIL b2b_src_off: got %b expected 0", src_ir); end
   endtask

   task automatic test_ovf();
      loc_val = 8'd200; loc_sign = 1'b0;
      step(1); // e42
      n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_200: got %b expected 1", ovf); end
      n_tests++; if (seg !== 7'b0000100) begin n_fail++; $display("FAIL ovf_units: got %b expected 0000100", seg); end
      n_tests++; if (sign_led !== 1'b0) begin n_fail++; $display("FAIL ovf_sign: got %b expected 0", sign_led); end
      step(2); // e44
      n_tests++; if (seg !== 7'b0000100 || an !== 2'b01) begin n_fail++; $display("FAIL ovf_tens: got seg=%b an=%b expected 0000100 01", seg, an); end
      loc_val = 8'd5;
      step(1); // e45
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_5: got %b expected 0", ovf); end
      n_tests++; if (seg !== TENS0) begin n_fail++; $display("FAIL tens_zero_5: got %b expected %b", seg, TENS0); end
      loc_val = 8'd100;
      step(1); // e46
      n_tests++; if (ovf !== 1'b1 || seg !== 7'b0000100) begin n_fail++; $display("FAIL ovf_100: got ovf=%b seg=%b expected 1 0000100", ovf, seg); end
      loc_val = 8'd99;
      step(1); // e47
      n_tests++; if (ovf !== 1'b0 || seg !== 7'b0000100) begin n_fail++; $display("FAIL ovf_99: got ovf=%b seg=%b expected 0 0000100", ovf, seg); end
   endtask

   task automatic test_lead_blank();
      loc_val = 8'd3;
      step(1); // e48
      n_tests++; if (an !== 2'b10 || seg !== 7'b0000110) begin n_fail++; $display("FAIL blank_units: got an=%b seg=%b expected 10 0000110", an, seg); end
      step(4); // e52
      n_tests++; if (an !== 2'b01 || seg !== TENS0) begin n_fail++; $display("FAIL blank_tens: got an=%b seg=%b expected 01 %b", an, seg, TENS0); end
   endtask

   task automatic test_expiry_collision();
      ir_valid = 1'b1; ir_val = 8'd8; ir_sign = 1'b0;
      step(1); // e53
      ir_valid = 1'b0;
      for (int i = 54; i <= 64; i++) begin
         step(1);
         n_tests++; if (src_ir !== 1'b1) begin n_fail++; $display("FAIL coll_hold_e%0d: got %b expected 1", i, src_ir); end
      end
      ir_valid = 1'b1; ir_val = 8'd23;
      step(1); // e65: expiry and new value coincide
      ir_valid = 1'b0;
      n_tests++; if (src_ir !== 1'b1) begin n_fail++; $display("FAIL coll_src: got %b expected 1", src_ir); end
      n_tests++; if (an !== 2'b10 || seg !== 7'b0000110) begin n_fail++; $display("FAIL coll_seg: got an=%b seg=%b expected 10 0000110", an, seg); end
      step(2); // e67
      n_tests++; if (src_ir !== 1'b1) begin n_fail++; $display("FAIL coll_src_e67: got %b expected 1", src_ir); end
      rst_n = 1'b0;
      step(1);
      n_tests++; if (src_ir !== 1'b0 || seg !== 7'b0000001) begin n_fail++; $display("FAIL midrst: got src=%b seg=%b expected 0 0000001", src_ir, seg); end
      n_tests++; if (an !== 2'b10 || ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_an: got an=%b ovf=%b expected 10 0", an, ovf); end
      rst_n = 1'b1;
      step(1);
      n_tests++; if (src_ir !== 1'b0 || seg !== 7'b0000110) begin n_fail++; $display("FAIL post_rst_loc: got src=%b seg=%b expected 0 0000110", src_ir, seg); end
   endtask

   initial begin
      test_reset();
      test_local();
      test_ir();
      test_back_to_back();
      test_ovf();
      test_lead_blank();
      test_expiry_collision();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
